// File: rtl/jt10_adpcm_addrgen_if.sv
// Bus bundle for jt10_adpcm_addrgen: per-slot control inputs and registered ROM-side outputs.
interface jt10_adpcm_addrgen_if #(
   parameter int CH  = 6,
   parameter int SW  = 12,
   parameter int LSB = 9
);
   localparam int CW = (CH > 1) ? $clog2(CH) : 1;

   logic                  cen;
   logic                  adv;
   logic [SW-1:0]         addr_in;
   logic                  up_start;
   logic                  up_end;
   logic                  up_loop;
   logic                  loop_in;
   logic                  aon;
   logic                  aoff;
   logic [CH-1:0]         flag_clr;
   logic [CW-1:0]         cur_ch;
   logic [CW-1:0]         out_ch;
   logic [SW+LSB-2:0]     addr_out;
   logic                  sel;
   logic                  roe_n;
   logic [CH-1:0]         flags;

   modport master (
      output cen, adv, addr_in, up_start, up_end, up_loop, loop_in, aon, aoff, flag_clr,
      input  cur_ch, out_ch, addr_out, sel, roe_n, flags
   );

   modport slave (
      input  cen, adv, addr_in, up_start, up_end, up_loop, loop_in, aon, aoff, flag_clr,
      output cur_ch, out_ch, addr_out, sel, roe_n, flags
   );
endinterface

// File: rtl/jt10_adpcm_addrgen.sv
// Time-multiplexed ADPCM-A address generator: one shared update visits CH channel slots round-robin.
// Optional end-of-sample looping is built when JT10_ADPCM_LOOP_EN is defined.
module jt10_adpcm_addrgen #(
   parameter int CH  = 6,
   parameter int SW  = 12,
   parameter int LSB = 9
) (
   input  logic                   clk,
   input  logic                   rst_n,
   jt10_adpcm_addrgen_if.slave    bus
);
   localparam int AW = SW + LSB;
   localparam int CW = (CH > 1) ? $clog2(CH) : 1;

   logic [CW-1:0]  cur_ch;
   logic [CW-1:0]  out_ch;
   logic [AW-1:0]  addr_q;
   logic           roe_q;
   logic [CH-1:0]  flags;

   logic [SW-1:0]  start_mem [CH];
   logic [SW-1:0]  end_mem   [CH];
   logic [AW-1:0]  cnt_mem   [CH];
   logic [CH-1:0]  on_mem;
`ifdef JT10_ADPCM_LOOP_EN
   logic [CH-1:0]  loop_mem;
`else
   logic           unused_loop;
   assign unused_loop = &{1'b0, bus.up_loop, bus.loop_in};
`endif

   logic [SW-1:0]  s_new;
   logic [SW-1:0]  e_new;
   logic           l_new;
   logic [AW-1:0]  cnt_cur;
   logic           on_cur;
   logic           at_end;
   logic [AW-1:0]  cnt_nxt;
   logic           on_nxt;
   logic           flag_set;
   logic [CH-1:0]  set_vec;

   always_comb begin
      s_new    = bus.up_start ? bus.addr_in : start_mem[cur_ch];
      e_new    = bus.up_end   ? bus.addr_in : end_mem[cur_ch];
`ifdef JT10_ADPCM_LOOP_EN
      l_new    = bus.up_loop  ? bus.loop_in : loop_mem[cur_ch];
`else
      l_new    = 1'b0;
`endif
      cnt_cur  = cnt_mem[cur_ch];
      on_cur   = on_mem[cur_ch];
      at_end   = (cnt_cur[AW-1:LSB] == e_new);
      cnt_nxt  = cnt_cur;
      on_nxt   = on_cur;
      flag_set = 1'b0;
      if (bus.aoff) begin
         on_nxt = 1'b0;
      end else if (bus.aon && !on_cur) begin
         on_nxt  = 1'b1;
         cnt_nxt = {s_new, {LSB{1'b0}}};
      end else if (on_cur && at_end) begin
         flag_set = 1'b1;
         if (l_new) begin
            if (bus.adv) cnt_nxt = {s_new, {LSB{1'b0}}};
         end else begin
            on_nxt = 1'b0;
         end
      end else if (on_cur && bus.adv) begin
         cnt_nxt = cnt_cur + 1'b1;
      end
      set_vec = (bus.cen && flag_set) ? (CH'(1) << cur_ch) : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur_ch <= '0;
         out_ch <= '0;
         addr_q <= '0;
         roe_q  <= 1'b1;
         on_mem <= '0;
`ifdef JT10_ADPCM_LOOP_EN
         loop_mem <= '0;
`endif
         for (int unsigned i = 0; i < CH; i++) begin
            start_mem[i] <= '0;
            end_mem[i]   <= '0;
            cnt_mem[i]   <= '0;
         end
      end else if (bus.cen) begin
         cur_ch            <= (cur_ch == CW'(CH-1)) ? '0 : cur_ch + 1'b1;
         start_mem[cur_ch] <= s_new;
         end_mem[cur_ch]   <= e_new;
         cnt_mem[cur_ch]   <= cnt_nxt;
         on_mem[cur_ch]    <= on_nxt;
`ifdef JT10_ADPCM_LOOP_EN
         loop_mem[cur_ch]  <= l_new;
`endif
         // Outputs describe the slot as it was before this update.
         out_ch <= cur_ch;
         addr_q <= cnt_cur;
         roe_q  <= !(on_cur && !at_end);
      end
   end

   // Clears act every clock; a simultaneous set on the same bit wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) flags <= '0;
      else        flags <= (flags & ~bus.flag_clr) | set_vec;
   end

   assign bus.cur_ch   = cur_ch;
   assign bus.out_ch   = out_ch;
   assign bus.addr_out = addr_q[AW-1:1];
   assign bus.sel      = addr_q[0];
   assign bus.roe_n    = roe_q;
   assign bus.flags    = flags;
endmodule
